// File: rtl/rv_reg_file.sv
// RV32I integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional write-through bypass (WB -> ID same cycle) enabled by defining REGFILE_BYPASS_EN.
module rv_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] reg1_addr_i,
    input  logic [ADDR_WIDTH-1:0] reg2_addr_i,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic [DATA_WIDTH-1:0] data2_o,
    input  logic [ADDR_WIDTH-1:0] writereg_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_write_i
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic                  write_en_s;
    logic [DATA_WIDTH-1:0] data1_s;
    logic [DATA_WIDTH-1:0] data2_s;

    // Reset clears every entry; entry 0 is never written so it stays zero.
    assign write_en_s = data_write_i && (writereg_addr_i != {ADDR_WIDTH{1'b0}});

    // Register storage: reset has priority over the write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (write_en_s) begin
            regs_r[writereg_addr_i] <= data_i;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass_hit_s;
    assign bypass_hit_s = reset_n && write_en_s;

    // Read port 1 with write-through bypass.
    always_comb begin
        data1_s = {DATA_WIDTH{1'b0}};
        if (reg1_addr_i == {ADDR_WIDTH{1'b0}}) begin
            data1_s = {DATA_WIDTH{1'b0}};
        end else if (bypass_hit_s && (reg1_addr_i == writereg_addr_i)) begin
            data1_s = data_i;
        end else begin
            data1_s = regs_r[reg1_addr_i];
        end
    end

    // Read port 2 with write-through bypass.
    always_comb begin
        data2_s = {DATA_WIDTH{1'b0}};
        if (reg2_addr_i == {ADDR_WIDTH{1'b0}}) begin
            data2_s = {DATA_WIDTH{1'b0}};
        end else if (bypass_hit_s && (reg2_addr_i == writereg_addr_i)) begin
            data2_s = data_i;
        end else begin
            data2_s = regs_r[reg2_addr_i];
        end
    end
`else
    // Read port 1: stored contents only; x0 forced to zero.
    always_comb begin
        data1_s = {DATA_WIDTH{1'b0}};
        if (reg1_addr_i == {ADDR_WIDTH{1'b0}}) begin
            data1_s = {DATA_WIDTH{1'b0}};
        end else begin
            data1_s = regs_r[reg1_addr_i];
        end
    end

    // Read port 2: stored contents only; x0 forced to zero.
    always_comb begin
        data2_s = {DATA_WIDTH{1'b0}};
        if (reg2_addr_i == {ADDR_WIDTH{1'b0}}) begin
            data2_s = {DATA_WIDTH{1'b0}};
        end else begin
            data2_s = regs_r[reg2_addr_i];
        end
    end
`endif

    assign data1_o = data1_s;
    assign data2_o = data2_s;

endmodule

// File: tb/tb_rv_reg_file.sv
// Self-checking bench for rv_reg_file: directed vector table, reset corner sequences, randomized model compare.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_rv_reg_file;

    logic        clk;
    logic        reset_n;
    logic [4:0]  reg1_addr_i;
    logic [4:0]  reg2_addr_i;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [4:0]  writereg_addr_i;
    logic [31:0] data_i;
    logic        data_write_i;

    int checks;
    int errors;
    logic [31:0] model [32];

    rv_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .reg1_addr_i    (reg1_addr_i),
        .reg2_addr_i    (reg2_addr_i),
        .data1_o        (data1_o),
        .data2_o        (data2_o),
        .writereg_addr_i(writereg_addr_i),
        .data_i         (data_i),
        .data_write_i   (data_write_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected read value from the architectural rules applied to the model.
    function automatic logic [31:0] expect_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && reset_n && data_write_i && writereg_addr_i != 5'd0 && writereg_addr_i == a)
            return data_i;
        return model[a];
    endfunction

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset_n = rst; data_write_i = we; writereg_addr_i = wa;
        data_i = wd; reg1_addr_i = r1; reg2_addr_i = r2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (data_write_i && writereg_addr_i != 5'd0) begin
            model[writereg_addr_i] = data_i;
        end
        @(negedge clk);
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            check({name, "_p1"}, data1_o, 32'd0);
            check({name, "_p2"}, data2_o, 32'd0);
        end
    endtask

    vec_t vecs [13];

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 32'd0, BYP ? 32'hDEADBEEF : 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 5'd0,  32'd0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'd0,        5'd4,  5'd6,  32'd0, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'd0, 32'd0};
        vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'd0,        5'd0,  5'd0,  32'd0, 32'd0};
        vecs[5]  = '{1'b1, 1'b1, 5'd7,  32'h11111111, 5'd7,  5'd5,  BYP ? 32'h11111111 : 32'd0, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b0, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h11111111, 32'h11111111};
        vecs[7]  = '{1'b1, 1'b0, 5'd0,  32'd0,        5'd7,  5'd7,  32'h11111111, 32'h11111111};
        vecs[8]  = '{1'b1, 1'b1, 5'd10, 32'hAAAA0000, 5'd10, 5'd10, BYP ? 32'hAAAA0000 : 32'd0, BYP ? 32'hAAAA0000 : 32'd0};
        vecs[9]  = '{1'b1, 1'b1, 5'd10, 32'h5555FFFF, 5'd10, 5'd7,  BYP ? 32'h5555FFFF : 32'hAAAA0000, 32'h11111111};
        vecs[10] = '{1'b1, 1'b0, 5'd0,  32'd0,        5'd10, 5'd10, 32'h5555FFFF, 32'h5555FFFF};
        vecs[11] = '{1'b0, 1'b1, 5'd3,  32'hFFFFFFFF, 5'd3,  5'd5,  32'd0, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 1'b0, 5'd0,  32'd0,        5'd5,  5'd3,  32'd0, 32'd0};

        // Initial reset edge; outputs are undefined before it so nothing is checked.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);
        tick();
        sweep_zero("reset_sweep");

        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].rst_n, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].r1, vecs[v].r2);
            check($sformatf("vec%0d_p1", v), data1_o, vecs[v].exp1);
            check($sformatf("vec%0d_p2", v), data2_o, vecs[v].exp2);
            tick();
        end

        // Fill x1..x31, then reset while writing x3: everything must read zero.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'(i - 1), 5'(i));
            check("fill_p1", data1_o, expect_rd(5'(i - 1)));
            check("fill_p2", data2_o, expect_rd(5'(i)));
            tick();
        end
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31);
        check("filled_x3", data1_o, 32'h1000_0003);
        check("filled_x31", data2_o, 32'h1000_001F);
        drive(1'b0, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd3);
        check("rst_wr_p1", data1_o, 32'h1000_0003);
        tick();
        sweep_zero("reset_vs_write");

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 24) != 0), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) reg2_addr_i = writereg_addr_i;
            if ($urandom_range(0, 3) == 0) reg1_addr_i = writereg_addr_i;
            #1;
            check("rand_p1", data1_o, expect_rd(reg1_addr_i));
            check("rand_p2", data2_o, expect_rd(reg2_addr_i));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
